// File: rtl/uart_receiving_msg.sv
// Multi-byte 8N1 UART receiver: assembles msg_size_byte bytes (first byte in
// the low byte) into one message word and strobes msg_valid on completion.
module uart_receiving_msg #(
  parameter int unsigned clk_freq      = 1000000,
  parameter int unsigned baud_rate     = 9600,
  parameter int unsigned msg_size_byte = 4,
  parameter int unsigned timeout_bits  = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic [8*msg_size_byte-1:0] msg,
  output logic                       msg_valid,
  output logic                       frame_error,
  output logic                       busy
);

  localparam int unsigned BP      = clk_freq / baud_rate;
  localparam int unsigned HP      = BP / 2;
  localparam int unsigned MSG_W   = 8 * msg_size_byte;
  localparam int unsigned CNT_W   = (BP > 1) ? $clog2(BP) : 1;
  localparam int unsigned BYTE_W  = (msg_size_byte > 1) ? $clog2(msg_size_byte) : 1;
  localparam int unsigned TO_CYC  = timeout_bits * BP;
  localparam int unsigned TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;
  localparam int unsigned IDLE_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam bit          TO_EN   = (timeout_bits != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q;
  logic                rx_meta_q;
  logic                rx_s_q;
  logic                armed_q;
  logic [CNT_W-1:0]    baud_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic [BYTE_W-1:0]   byte_cnt_q;
  logic [MSG_W-1:0]    buf_q;
  logic [MSG_W-1:0]    msg_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                msg_valid_q;
  logic                frame_error_q;

  logic                half_tick_c;
  logic                bit_tick_c;
  logic [MSG_W-1:0]    buf_ins_c;

  // Baud counter terminal counts: mid start bit, and one full bit later
  assign half_tick_c = (baud_q == CNT_W'(HP - 1));
  assign bit_tick_c  = (baud_q == CNT_W'(BP - 1));

  // Partial buffer with the just-received byte placed in its slot
  always_comb begin
    buf_ins_c = buf_q;
    for (int unsigned i = 0; i < msg_size_byte; i++) begin
      if (byte_cnt_q == BYTE_W'(i)) begin
        buf_ins_c[8*i +: 8] = shift_q;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous serial line, idle-high preset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM, byte assembly, inter-byte timeout and output strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b1;
      baud_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      buf_q         <= '0;
      msg_q         <= '0;
      idle_q        <= '0;
      msg_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      msg_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          // After a framing error the line must be seen idle before re-arming
          if (rx_s_q) begin
            armed_q <= 1'b1;
          end
          if (armed_q && !rx_s_q) begin
            state_q <= S_START;
            idle_q  <= '0;
          end else if (TO_EN && (byte_cnt_q != '0)) begin
            if (idle_q == IDLE_W'(TO_LAST)) begin
              byte_cnt_q <= '0;
              buf_q      <= '0;
              idle_q     <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end else begin
            idle_q <= '0;
          end
        end

        S_START: begin
          if (half_tick_c) begin
            baud_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_tick_c) begin
            baud_q    <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_tick_c) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
            if (rx_s_q) begin
              if (byte_cnt_q == BYTE_W'(msg_size_byte - 1)) begin
                msg_q       <= buf_ins_c;
                msg_valid_q <= 1'b1;
                byte_cnt_q  <= '0;
                buf_q       <= '0;
              end else begin
                buf_q      <= buf_ins_c;
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end else begin
              frame_error_q <= 1'b1;
              byte_cnt_q    <= '0;
              buf_q         <= '0;
              armed_q       <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign msg         = msg_q;
  assign msg_valid   = msg_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE) || (byte_cnt_q != '0);

endmodule

// File: doc/uart_receiving_msg.md
Name: uart_receiving_msg

Overview:
Multi-byte UART receiver: deserialises an 8N1 stream on rx and assembles msg_size_byte bytes into one wide message word, strobing msg_valid when complete. It is the receiving counterpart of uart_sending_msg, and bench-side it captures what a controller transmits. Byte order matches the sender: the first byte on the wire lands in msg[7:0], and the last byte lands in the top byte.

Parameters:
clk_freq, 1000000, system clock frequency in Hz
baud_rate, 9600, line rate in bit/s; bit period BP = clk_freq/baud_rate (integer floor), half period HP = BP/2
msg_size_byte, 4, number of bytes per message, must be at least 1
timeout_bits, 20, idle bit periods after which a partially received message is discarded; 0 disables the timeout

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low; 0 clears all state
rx  input  1  serial line, idle high, asynchronous to clk
msg  output  8*msg_size_byte  last complete message, held until the next one completes
msg_valid  output  1  one-cycle pulse when msg is updated
frame_error  output  1  one-cycle pulse when a stop bit samples 0
busy  output  1  high while any byte of a message is in progress, including between bytes

Behaviour:
- Reset (reset==0 at a clk edge) sets: msg=0, msg_valid=0, frame_error=0, busy=0, state=IDLE, byte count=0, partial buffer=0, baud counter=0. The rx synchroniser is preset to 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so there is 2 cycles of input latency.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: when rx_s==0, go to START and load the baud counter.
- START: wait HP cycles, then sample. If rx_s==1 (glitch), return to IDLE; the byte count is unchanged. If rx_s==0, go to DATA with bit index 0.
- DATA: sample every BP cycles, LSB first, shifting into the byte register. After bit 7, go to STOP.
- STOP: sample BP cycles after bit 7.
  - If rx_s==1, write the byte into partial buffer slot [byte_count], increment byte_count and return to IDLE.
  - When that byte completes the message (byte_count reaches msg_size_byte): on the same edge, copy the buffer (including the new byte) to msg, assert msg_valid for exactly 1 cycle, and reset byte_count to 0.
  - If rx_s==0: pulse frame_error for 1 cycle, discard the partial message (byte_count=0, buffer=0) and go to IDLE. IDLE does not re-arm until rx_s has been seen high at least once, so a break condition does not restart reception.
- busy = (state!=IDLE) or (byte_count!=0).
- Inter-byte timeout: with timeout_bits>0, in IDLE with byte_count!=0, an idle counter runs. When it reaches timeout_bits*BP cycles, byte_count and buffer are cleared, with no pulse. Any start edge clears the idle counter.
- msg_valid and frame_error are never high in the same cycle.
- msg keeps its value across framing errors, timeouts and reception in progress. Only reset or a completed message changes it.
- Latency: msg_valid rises 2 + HP + 9*BP cycles (±1) after the falling edge of the last start bit reaches the rx pin.
- Back-to-back frames with no idle time between the stop bit and the next start bit must be received. Because the stop bit is sampled mid-bit, the FSM is in IDLE before the next falling edge.
- Reset asserted mid-byte or mid-message drops everything. The first message after reset release starts from byte 0.

Test Plan:
- Defaults (BP=104). Send bytes 0x04,0x03,0x02,0x01 with 1 stop bit each. Expect msg=32'h01020304, one msg_valid pulse, busy=0 one cycle after the pulse, frame_error never asserted.
- msg_size_byte=6. Send 04,03,02,01,E9,E8 back-to-back with no idle gap. Expect msg=48'hE8E901020304 and exactly one msg_valid.
- Send 0x55 with the stop bit forced to 0, then 4 valid bytes 0xAA,0xBB,0xCC,0xDD. Expect a frame_error pulse, msg unchanged (0), then msg=32'hDDCCBBAA.
- Drive rx low for 30 cycles (shorter than HP=52). Expect a return to IDLE with no error and no byte counted; the next 4 bytes 0x11..0x44 give msg=32'h44332211.
- Send 2 bytes, wait 25 bit periods (more than timeout_bits), then send 4 bytes 0xA1..0xA4. Expect msg=32'hA4A3A2A1 with no pulse from the partial message. Repeat with timeout_bits=0 and the same stimulus: expect msg built from the 2 stale bytes plus the first 2 new ones.
- Pull reset low for 1 cycle mid-way through byte 2. Expect all outputs back to 0; a subsequent full 4-byte message is received correctly.
